// File: rtl/mc_ctrl_fsm_if.sv
// Instruction/data SRAM handshake bundle for the multi-cycle controller.
// master: the controller. It drives the requests and the store/load select,
//         and receives the ready flags.
// slave : the SRAM side, with the directions reversed.
//   inst_sram_req    fetch request
//   inst_sram_ready  fetch data valid this cycle
//   data_sram_req    data access request
//   data_sram_wr     1 = store, 0 = load; valid with data_sram_req
//   data_sram_ready  data access complete / read data valid this cycle
interface mc_ctrl_fsm_if;
   logic inst_sram_req;
   logic inst_sram_ready;
   logic data_sram_req;
   logic data_sram_wr;
   logic data_sram_ready;

   modport master (
      output inst_sram_req, data_sram_req, data_sram_wr,
      input  inst_sram_ready, data_sram_ready
   );
   modport slave (
      input  inst_sram_req, data_sram_req, data_sram_wr,
      output inst_sram_ready, data_sram_ready
   );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle LA32R control sequencer: IF -> ID -> EXE -> MEM -> WB.
// It waits on the SRAM ready handshakes and emits one-cycle write strobes for
// IR, the ALU-result latch, MDR, the register file and PC.
// Ports:
//   clk, resetn        clock; synchronous active-low reset
//   sram               SRAM handshake bundle (mc_ctrl_fsm_if.master)
//   dec_*              decoder instruction class, sampled in ID only
//   ir_we ... retire   write strobes and the retire pulse (combinational)
//   state              current state: IF=0 ID=1 EXE=2 MEM=3 WB=4 ERR=5
//   err                sticky handshake-timeout flag
//   cycle_cnt          cycles since reset
//   instret_cnt        retired instructions
// Define MC_PERF_CNT_EN to build the performance counters. When it is not
// defined, cycle_cnt and instret_cnt read 0.
module mc_ctrl_fsm #(
   parameter logic [15:0] TIMEOUT = 16'd1023,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             resetn,
   mc_ctrl_fsm_if.master    sram,
   input  logic             dec_br_only,
   input  logic             dec_load,
   input  logic             dec_store,
   input  logic             dec_gr_we,
   output logic             ir_we,
   output logic             exe_we,
   output logic             mdr_we,
   output logic             rf_we,
   output logic             pc_we,
   output logic             retire,
   output logic [2:0]       state,
   output logic             err,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   typedef enum logic [2:0] {
      StIf  = 3'd0,
      StId  = 3'd1,
      StExe = 3'd2,
      StMem = 3'd3,
      StWb  = 3'd4,
      StErr = 3'd5
   } state_e;

   state_e      state_q, state_d;
   logic        ld_q, ld_d;
   logic        st_q, st_d;
   logic        gr_we_q, gr_we_d;
   logic [15:0] wait_q, wait_d;
   logic        err_q, err_d;
   logic        waiting;

   always_comb begin
      state_d              = state_q;
      ld_d                 = ld_q;
      st_d                 = st_q;
      gr_we_d              = gr_we_q;
      err_d                = err_q;
      wait_d               = '0;
      waiting              = 1'b0;
      ir_we                = 1'b0;
      exe_we               = 1'b0;
      mdr_we               = 1'b0;
      rf_we                = 1'b0;
      pc_we                = 1'b0;
      retire               = 1'b0;
      sram.inst_sram_req   = 1'b0;
      sram.data_sram_req   = 1'b0;
      sram.data_sram_wr    = 1'b0;

      case (state_q)
         StIf: begin
            sram.inst_sram_req = 1'b1;
            if (sram.inst_sram_ready) begin
               ir_we   = 1'b1;
               state_d = StId;
            end else begin
               waiting = 1'b1;
            end
         end
         StId: begin
            // Class priority: br_only > load > store.
            ld_d    = dec_load & ~dec_br_only;
            st_d    = dec_store & ~dec_load & ~dec_br_only;
            gr_we_d = dec_gr_we;
            if (dec_br_only) begin
               pc_we   = 1'b1;
               retire  = 1'b1;
               state_d = StIf;
            end else begin
               state_d = StExe;
            end
         end
         StExe: begin
            exe_we  = 1'b1;
            state_d = (ld_q | st_q) ? StMem : StWb;
         end
         StMem: begin
            sram.data_sram_req = 1'b1;
            sram.data_sram_wr  = st_q;
            if (sram.data_sram_ready) begin
               if (ld_q) begin
                  mdr_we  = 1'b1;
                  state_d = StWb;
               end else begin
                  pc_we   = 1'b1;
                  retire  = 1'b1;
                  state_d = StIf;
               end
            end else begin
               waiting = 1'b1;
            end
         end
         StWb: begin
            rf_we   = gr_we_q;
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = StIf;
         end
         StErr: begin
            state_d = StErr;
         end
         default: begin
            state_d = StIf;
         end
      endcase

      // The wait counter runs only while stalled on a handshake. Every other
      // cycle is either a state change or ERR, so it clears there.
      if (waiting) begin
         wait_d = wait_q + 16'd1;
         if ((TIMEOUT != 16'd0) && (wait_d == TIMEOUT)) begin
            state_d = StErr;
            err_d   = 1'b1;
         end
      end

      // While in reset the access is abandoned at once, even before the edge.
      if (!resetn) begin
         ir_we              = 1'b0;
         exe_we             = 1'b0;
         mdr_we             = 1'b0;
         rf_we              = 1'b0;
         pc_we              = 1'b0;
         retire             = 1'b0;
         sram.inst_sram_req = 1'b0;
         sram.data_sram_req = 1'b0;
         sram.data_sram_wr  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= StIf;
         ld_q    <= 1'b0;
         st_q    <= 1'b0;
         gr_we_q <= 1'b0;
         wait_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ld_q    <= ld_d;
         st_q    <= st_d;
         gr_we_q <= gr_we_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
      end
   end

   assign state = state_q;
   assign err   = err_q;

`ifdef MC_PERF_CNT_EN
   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [CNT_W-1:0] instret_q, instret_d;

   always_comb begin
      cycle_d   = cycle_q + CNT_W'(1);
      instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         cycle_q   <= cycle_d;
         instret_q <= instret_d;
      end
   end

   assign cycle_cnt   = cycle_q;
   assign instret_cnt = instret_q;
`else
   assign cycle_cnt   = '0;
   assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;
   localparam int unsigned CW = 32;

   logic          clk = 1'b0;
   logic          resetn;
   logic          dec_br_only, dec_load, dec_store, dec_gr_we;
   logic          ir_we, exe_we, mdr_we, rf_we, pc_we, retire, err;
   logic [2:0]    state;
   logic [CW-1:0] cycle_cnt, instret_cnt;

   int n_err = 0;
   int n_chk = 0;

   mc_ctrl_fsm_if bus ();

   mc_ctrl_fsm #(
      .TIMEOUT(16'd8),
      .CNT_W  (CW)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .sram       (bus.master),
      .dec_br_only(dec_br_only),
      .dec_load   (dec_load),
      .dec_store  (dec_store),
      .dec_gr_we  (dec_gr_we),
      .ir_we      (ir_we),
      .exe_we     (exe_we),
      .mdr_we     (mdr_we),
      .rf_we      (rf_we),
      .pc_we      (pc_we),
      .retire     (retire),
      .state      (state),
      .err        (err),
      .cycle_cnt  (cycle_cnt),
      .instret_cnt(instret_cnt)
   );

   always #5 clk = ~clk;

   // One cycle of stimulus plus the expected output vector:
   // exp = {state[2:0], ir, exe, mdr, rf, pc, retire, inst_req, data_req, data_wr, err}
   typedef struct packed {
      logic        irdy;
      logic        drdy;
      logic        br;
      logic        ld;
      logic        st;
      logic        gw;
      logic [12:0] exp;
   } cyc_t;

   cyc_t q[$];

   localparam int KAlu = 0, KBr = 1, KLd = 2, KSt = 3;

   function automatic logic rb();
      return 1'($urandom_range(1, 0));
   endfunction

   function automatic logic [12:0] act_vec();
      return {state, ir_we, exe_we, mdr_we, rf_we, pc_we, retire,
              bus.inst_sram_req, bus.data_sram_req, bus.data_sram_wr, err};
   endfunction

   task automatic push(input logic irdy, input logic drdy, input logic br, input logic ld,
                       input logic st, input logic gw, input logic [2:0] s,
                       input logic [8:0] strb, input logic e);
      cyc_t c;
      c.irdy = irdy; c.drdy = drdy; c.br = br; c.ld = ld; c.st = st; c.gw = gw;
      c.exp  = {s, strb, e};
      q.push_back(c);
   endtask

   // Reference trace of one instruction. Decoder inputs are noise outside ID,
   // and a ready whose request is low is noise too.
   // strb = {ir, exe, mdr, rf, pc, retire, inst_req, data_req, data_wr}
   task automatic model_instr(input int kind, input int wif, input int wmem, input logic gw);
      logic last;
      for (int i = 0; i <= wif; i++) begin
         last = (i == wif);
         push(last, rb(), rb(), rb(), rb(), rb(), 3'd0, {last, 5'b0, 3'b100}, 1'b0);
      end
      case (kind)
         KAlu:    push(rb(), rb(), 1'b0, 1'b0, 1'b0, gw, 3'd1, 9'b0, 1'b0);
         KBr:     push(rb(), rb(), 1'b1, rb(), rb(), rb(), 3'd1, 9'b000011000, 1'b0);
         KLd:     push(rb(), rb(), 1'b0, 1'b1, rb(), gw, 3'd1, 9'b0, 1'b0);
         default: push(rb(), rb(), 1'b0, 1'b0, 1'b1, gw, 3'd1, 9'b0, 1'b0);
      endcase
      if (kind != KBr) push(rb(), rb(), rb(), rb(), rb(), rb(), 3'd2, 9'b010000000, 1'b0);
      if (kind == KLd || kind == KSt) begin
         for (int j = 0; j <= wmem; j++) begin
            last = (j == wmem);
            push(rb(), last, rb(), rb(), rb(), rb(), 3'd3,
                 {2'b00, last && kind == KLd, 1'b0, last && kind == KSt, last && kind == KSt,
                  2'b01, kind == KSt}, 1'b0);
         end
      end
      if (kind == KAlu || kind == KLd)
         push(rb(), rb(), rb(), rb(), rb(), rb(), 3'd4, {3'b000, gw, 5'b11000}, 1'b0);
   endtask

   // Drives the queued trace. Entry is at a negedge with resetn high, and the
   // task returns at a negedge.
   task automatic play(input string name);
      int   idx = 0;
      cyc_t c;
      while (q.size() > 0) begin
         c = q.pop_front();
         bus.inst_sram_ready = c.irdy;
         bus.data_sram_ready = c.drdy;
         dec_br_only = c.br; dec_load = c.ld; dec_store = c.st; dec_gr_we = c.gw;
         #1;
         n_chk++;
         if (act_vec() !== c.exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, idx, act_vec(), c.exp);
         end
         idx++;
         @(negedge clk);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      resetn = 1'b0;
      bus.inst_sram_ready = 1'b0;
      bus.data_sram_ready = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      bus.inst_sram_ready = 1'b1;
      bus.data_sram_ready = 1'b1;
      dec_br_only = 1'b1; dec_load = 1'b1; dec_store = 1'b1; dec_gr_we = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_chk++;
      if (act_vec() !== 13'b0) begin
         n_err++;
         $display("FAIL reset_outputs: got %b expected %b", act_vec(), 13'b0);
      end
      n_chk++;
      if (cycle_cnt !== '0 || instret_cnt !== '0) begin
         n_err++;
         $display("FAIL reset_counters: got %0d/%0d expected 0/0", cycle_cnt, instret_cnt);
      end
   endtask

   task automatic test_alu();
      apply_reset();
      model_instr(KAlu, 0, 0, 1'b1);
      play("alu");
   endtask

   task automatic test_branch();
      apply_reset();
      model_instr(KBr, 2, 0, 1'b1);
      play("branch");
   endtask

   task automatic test_load();
      apply_reset();
      model_instr(KLd, 0, 3, 1'b1);
      play("load");
   endtask

   task automatic test_store();
      apply_reset();
      model_instr(KSt, 1, 1, 1'b1);
      play("store");
   endtask

   task automatic test_back_to_back();
      int n_ret = 0;
      int n_cyc;
      int k;
      int exp_ret, exp_cyc;
      apply_reset();
      for (int i = 0; i < 25; i++) begin
         k = int'($urandom_range(3, 0));
         model_instr(k, int'($urandom_range(4, 0)), int'($urandom_range(4, 0)), rb());
         n_ret++;
      end
      n_cyc = q.size();
      play("back_to_back");
`ifdef MC_PERF_CNT_EN
      exp_ret = n_ret;
      exp_cyc = n_cyc;
`else
      exp_ret = 0;
      exp_cyc = 0;
`endif
      n_chk++;
      if (instret_cnt !== CW'(exp_ret) || cycle_cnt !== CW'(exp_cyc)) begin
         n_err++;
         $display("FAIL b2b_counters: got %0d/%0d expected %0d/%0d",
                  instret_cnt, cycle_cnt, exp_ret, exp_cyc);
      end
   endtask

   task automatic test_timeout();
      apply_reset();
      for (int i = 0; i < 8; i++)
         push(1'b0, rb(), rb(), rb(), rb(), rb(), 3'd0, 9'b000000100, 1'b0);
      for (int i = 0; i < 3; i++)
         push(1'b1, 1'b1, rb(), rb(), rb(), rb(), 3'd5, 9'b0, 1'b1);
      play("timeout");
      resetn = 1'b0;
      #1;
      n_chk++;
      if (act_vec() !== {3'd5, 9'b0, 1'b1}) begin
         n_err++;
         $display("FAIL err_in_reset: got %b expected %b", act_vec(), {3'd5, 9'b0, 1'b1});
      end
      @(negedge clk);
      resetn = 1'b1;
      bus.inst_sram_ready = 1'b0;
      #1;
      n_chk++;
      if (act_vec() !== {3'd0, 9'b000000100, 1'b0}) begin
         n_err++;
         $display("FAIL err_cleared: got %b expected %b", act_vec(),
                  {3'd0, 9'b000000100, 1'b0});
      end
   endtask

   task automatic test_reset_mid_access();
      int exp_ret;
      int exp_cyc;
      apply_reset();
      for (int i = 0; i < 3; i++) model_instr(KAlu, 0, 0, 1'b1);
      model_instr(KLd, 0, 6, 1'b1);
      // Keep three ALU instructions plus IF, ID, EXE and two stalled MEM cycles.
      while (q.size() > 17) void'(q.pop_back());
      play("pre_mid_reset");
`ifdef MC_PERF_CNT_EN
      exp_ret = 3;
      exp_cyc = 17;
`else
      exp_ret = 0;
      exp_cyc = 0;
`endif
      resetn = 1'b0;
      bus.data_sram_ready = 1'b1;
      #1;
      n_chk++;
      if (act_vec() !== {3'd3, 9'b0, 1'b0}) begin
         n_err++;
         $display("FAIL mid_mem_reset: got %b expected %b", act_vec(), {3'd3, 9'b0, 1'b0});
      end
      n_chk++;
      if (instret_cnt !== CW'(exp_ret) || cycle_cnt !== CW'(exp_cyc)) begin
         n_err++;
         $display("FAIL pre_reset_counters: got %0d/%0d expected %0d/%0d",
                  instret_cnt, cycle_cnt, exp_ret, exp_cyc);
      end
      @(negedge clk);
      #1;
      n_chk++;
      if (act_vec() !== 13'b0 || cycle_cnt !== '0 || instret_cnt !== '0) begin
         n_err++;
         $display("FAIL post_reset: got %b cnt %0d/%0d expected %b cnt 0/0",
                  act_vec(), cycle_cnt, instret_cnt, 13'b0);
      end
      resetn = 1'b1;
      model_instr(KSt, 0, 0, 1'b1);
      play("after_mid_reset");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_alu();
      test_branch();
      test_load();
      test_store();
      test_back_to_back();
      test_timeout();
      test_reset_mid_access();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Control sequencer for the multi-cycle LA32R core. It steps each instruction through IF/ID/EXE/MEM/WB and waits on ready handshakes from the instruction and data SRAM ports. It emits the one-cycle write strobes that load the core's architectural and inter-stage registers: PC, IR, ALU-result latch, MDR and register file. It sits beside the datapath in the CPU top, driven by the decoder's instruction-class outputs.

Parameters:
TIMEOUT, 16'd1023, max consecutive wait cycles on a SRAM handshake before entering ERR; 0 disables the timeout
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  core clock
resetn  in  1  synchronous reset, active-low
inst_sram_req  out  1  instruction fetch request
inst_sram_ready  in  1  fetch data valid this cycle
data_sram_req  out  1  data access request
data_sram_wr  out  1  1 = store, 0 = load; valid with data_sram_req
data_sram_ready  in  1  data access complete / read data valid this cycle
dec_br_only  in  1  b/beq/bne (no EXE, no WB); sampled in ID only
dec_load  in  1  ld.w; sampled in ID only
dec_store  in  1  st.w; sampled in ID only
dec_gr_we  in  1  instruction writes a GPR; sampled in ID only
ir_we  out  1  latch IR
exe_we  out  1  latch ALU result
mdr_we  out  1  latch load data
rf_we  out  1  register-file write enable
pc_we  out  1  commit next PC
retire  out  1  one pulse per completed instruction
state  out  3  current state: IF=0 ID=1 EXE=2 MEM=3 WB=4 ERR=5
err  out  1  sticky timeout flag
cycle_cnt  out  CNT_W  cycles since reset (optional feature)
instret_cnt  out  CNT_W  retired instructions (optional feature)

Behaviour:
- resetn sampled low at posedge: state=IF, class regs=0, wait counter=0, err=0, counters=0.
- While resetn=0, all strobe/req outputs are forced 0 combinationally.
- All strobes are combinational from state, class regs and ready (Moore/Mealy mix). Every strobe is a 1-cycle pulse.
- IF:
  - inst_sram_req=1.
  - On inst_sram_ready: ir_we=1; next state ID.
  - Otherwise stay in IF; wait counter +1.
- ID (1 cycle):
  - Register the dec_* inputs into class regs.
  - Decode priority: br_only > load > store.
  - br_only: pc_we=1, retire=1, next IF.
  - Otherwise next EXE.
- EXE (1 cycle):
  - exe_we=1.
  - load|store: next MEM; otherwise next WB.
- MEM:
  - data_sram_req=1; data_sram_wr=store.
  - On data_sram_ready, load: mdr_we=1, next WB.
  - On data_sram_ready, store: pc_we=1, retire=1, next IF.
  - Otherwise stay in MEM; wait counter +1.
- WB (1 cycle):
  - rf_we=gr_we (class reg); pc_we=1; retire=1; next IF.
- Wait counter: cleared on every state change.
  - When TIMEOUT≠0 and the counter reaches TIMEOUT while still waiting, next state is ERR.
- ERR:
  - err=1; all strobes and reqs are 0.
  - Only resetn exits ERR.
- Ready asserted while the matching req=0 is ignored.
- Ready in the same cycle req first rises is accepted (0-wait SRAM).
- Reset mid-MEM or mid-IF:
  - The access is abandoned and req drops in the same cycle.
  - No strobe fires.
  - IF is entered at the next edge after resetn returns high.
- Illegal/unknown state encodings recover to IF.
- Instruction latency in cycles, with W = wait cycles:
  - branch: 2+W
  - ALU/jirl/bl: 4+W
  - store: 4+W_if+W_mem
  - load: 5+W_if+W_mem

Optional Feature:
MC_PERF_CNT_EN
- Defined:
  - cycle_cnt increments every cycle with resetn=1, including in ERR.
  - instret_cnt increments on each retire.
  - Both wrap modulo 2^CNT_W and clear on reset.
- Undefined: both outputs tied to 0; no counter flops.

Test Plan:
1. add.w, 0-wait fetch -> states 0,1,2,4; ir_we c1, exe_we c3, rf_we=1 c4, pc_we+retire c4; next IF c5.
2. beq, fetch ready after 2 wait cycles -> IF lasts 3 cycles, ID c4 with pc_we=1/retire=1; exe_we and rf_we never asserted.
3. ld.w, 0-wait fetch, data ready on 4th MEM cycle -> data_sram_wr=0 for 4 cycles, mdr_we on that cycle, rf_we in WB; 8 cycles total.
4. st.w with dec_gr_we=1, 1 data wait -> data_sram_wr=1 for 2 cycles; pc_we+retire on the ready cycle; rf_we never asserted; back to IF.
5. TIMEOUT=8, inst_sram_ready held 0 -> 8 req cycles then state=5, err=1, req=0; later ready=1 ignored; resetn=0 for 1 cycle -> state=0, err=0.
6. MC_PERF_CNT_EN, 3 ALU instructions with 0-wait, then resetn low during MEM of a ld.w -> req drops the same cycle; instret_cnt=3 before reset, both counters 0 after.
